// File: rtl/relu_maxpool_2x2_pkg.sv
// Shared constants and the signed max helper for the ReLU + 2x2 max-pool stage.
// Build option RELU_EN selects ReLU on the input (undefined: pure signed max pool).
package cnn_pool_pkg;

    localparam int CONV_OUT_W     = 2 * 8 + 6;
    localparam int DEF_IMG_WIDTH  = 62;
    localparam int DEF_IMG_HEIGHT = 62;

    // Wide enough for any sample width; callers sign-extend in, truncate out
    localparam int SMAX_W = 64;

    typedef logic signed [SMAX_W-1:0] swide_t;

    function automatic swide_t smax(input swide_t a, input swide_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/relu_maxpool_2x2_if.sv
// Valid-only pixel stream into the pool stage and pooled stream out of it.
// No ready signal: the pooled-stream consumer is always ready.
interface relu_maxpool_2x2_if
    import cnn_pool_pkg::*;
#(
    parameter int DATA_WIDTH = CONV_OUT_W
);

    logic signed [DATA_WIDTH-1:0] pixel_in;
    logic                         pixel_valid;
    logic signed [DATA_WIDTH-1:0] pool_out;
    logic                         pool_valid;
    logic                         frame_done;

    modport master (
        output pixel_in,
        output pixel_valid,
        input  pool_out,
        input  pool_valid,
        input  frame_done
    );

    modport slave (
        input  pixel_in,
        input  pixel_valid,
        output pool_out,
        output pool_valid,
        output frame_done
    );

endinterface

// File: rtl/relu_maxpool_2x2_line_buffer.sv
// Half-row buffer of horizontal maxima from the even row of each row pair.
// Combinational read, synchronous write, storage is never reset.
module pool_line_buffer #(
    parameter int DATA_WIDTH = 22,
    parameter int DEPTH      = 31,
    parameter int AW         = 5
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [AW-1:0]                waddr,
    input  logic signed [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]                raddr,
    output logic signed [DATA_WIDTH-1:0] rdata
);

    logic signed [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/relu_maxpool_2x2.sv
// ReLU followed by 2x2 stride-2 max pooling on a raster-order conv stream.
// Build option RELU_EN: when undefined the ReLU is bypassed.
module relu_maxpool_2x2
    import cnn_pool_pkg::*;
#(
    parameter int DATA_WIDTH = CONV_OUT_W,
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
    input logic               clk,
    input logic               rst,
    relu_maxpool_2x2_if.slave bus
);

    localparam int HALF_W = IMG_WIDTH / 2;
    localparam int CW     = cnt_w(IMG_WIDTH);
    localparam int RW     = cnt_w(IMG_HEIGHT);
    localparam int AW     = cnt_w(HALF_W);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] COL_END  = CW'((IMG_WIDTH / 2) * 2 - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_END  = RW'((IMG_HEIGHT / 2) * 2 - 1);

    logic [CW-1:0] col_cnt;
    logic [RW-1:0] row_cnt;

    logic signed [DATA_WIDTH-1:0] relu;
    logic signed [DATA_WIDTH-1:0] pair_reg;
    logic signed [DATA_WIDTH-1:0] hmax;
    logic signed [DATA_WIDTH-1:0] vmax;
    logic signed [DATA_WIDTH-1:0] buf_rd;
    logic signed [DATA_WIDTH-1:0] pool_q;
    logic                         valid_q;
    logic                         done_q;

    logic          col_used;
    logic          row_used;
    logic          pair_we;
    logic          buf_we;
    logic          out_fire;
    logic          last_blk;
    logic [AW-1:0] idx;

`ifdef RELU_EN
    assign relu = bus.pixel_in[DATA_WIDTH-1] ? '0 : bus.pixel_in;
`else
    assign relu = bus.pixel_in;
`endif

    // Trailing column/row of an odd dimension is counted but never paired
    assign col_used = (IMG_WIDTH % 2 == 0) || (col_cnt != COL_LAST);
    assign row_used = (IMG_HEIGHT % 2 == 0) || (row_cnt != ROW_LAST);

    assign pair_we  = bus.pixel_valid && !col_cnt[0] && col_used;
    assign buf_we   = bus.pixel_valid && col_cnt[0] && !row_cnt[0] && row_used;
    assign out_fire = bus.pixel_valid && col_cnt[0] && row_cnt[0];
    assign last_blk = (row_cnt == ROW_END) && (col_cnt == COL_END);

    assign idx  = AW'(col_cnt >> 1);
    assign hmax = DATA_WIDTH'(smax(SMAX_W'(pair_reg), SMAX_W'(relu)));
    assign vmax = DATA_WIDTH'(smax(SMAX_W'(buf_rd), SMAX_W'(hmax)));

    pool_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (HALF_W),
        .AW         (AW)
    ) u_line_buffer (
        .clk   (clk),
        .we    (buf_we),
        .waddr (idx),
        .wdata (hmax),
        .raddr (idx),
        .rdata (buf_rd)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (bus.pixel_valid) begin
            if (col_cnt == COL_LAST) begin
                col_cnt <= '0;
                row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
            end else begin
                col_cnt <= col_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pair_reg <= '0;
        end else if (pair_we) begin
            pair_reg <= relu;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pool_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= out_fire;
            done_q  <= out_fire && last_blk;
            if (out_fire) begin
                pool_q <= vmax;
            end
        end
    end

    assign bus.pool_out   = pool_q;
    assign bus.pool_valid = valid_q;
    assign bus.frame_done = done_q;

endmodule

// File: doc/relu_maxpool_2x2.md
Name: relu_maxpool_2x2

Overview:
- Downstream consumer of the RGB conv layer's per-filter output stream. Accepts one signed conv result per cycle, in raster order.
- Applies ReLU, then 2x2/stride-2 max pooling, and emits one pooled pixel per 2x2 block.
- One instance is placed per filter output lane. Its output feeds the next rgb window generator stage.
- No backpressure: the consumer is always ready, consistent with the existing valid-only streaming.

Parameters:
- DATA_WIDTH, 22, width of the signed input sample (2*8+6 from the first conv stage).
- IMG_WIDTH, 62, input pixels per row (conv output width).
- IMG_HEIGHT, 62, input rows per frame.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- pixel_in  input  DATA_WIDTH  signed conv result.
- pixel_valid  input  1  pixel_in is valid this cycle.
- pool_out  output  DATA_WIDTH  pooled pixel, signed two's complement.
- pool_valid  output  1  pool_out is valid; one-cycle pulse per 2x2 block.
- frame_done  output  1  one-cycle pulse coincident with the last pool_valid of a frame.

Behaviour:
- Reset (rst=0, async): col_cnt=0, row_cnt=0, pair_reg=0, pool_out=0, pool_valid=0, frame_done=0.
  - Line buffer contents are don't-care; every even row overwrites them before they are read.
- Counting:
  - col_cnt advances only on pixel_valid and wraps at IMG_WIDTH-1.
  - row_cnt increments on the col_cnt wrap and wraps at IMG_HEIGHT-1, then the next frame begins.
  - Gaps in pixel_valid hold all state.
- ReLU stage (combinational): r = (pixel_in < 0) ? 0 : pixel_in.
- Horizontal pairing:
  - On valid with even col_cnt, latch r into pair_reg.
  - On valid with odd col_cnt, h = max(pair_reg, r) is a signed compare.
- Vertical pairing:
  - Line buffer has floor(IMG_WIDTH/2) entries of DATA_WIDTH, indexed col_cnt>>1.
  - Even row, odd col: buffer[idx] <= h.
  - Odd row, odd col: pool_out <= max(buffer[idx], h) and pool_valid <= 1 at the next clock edge.
- Latency: pool_valid asserts one cycle after the accepting edge of the block's bottom-right pixel.
- Output hold: pool_out holds its last value when pool_valid=0.
- Odd dimensions:
  - If IMG_WIDTH is odd, the last column is counted but ignored: no pair_reg write used, no buffer write.
  - If IMG_HEIGHT is odd, the last row is counted but produces no output.
- Output counts: pooled frame is floor(IMG_WIDTH/2) x floor(IMG_HEIGHT/2), i.e. 31x31=961 pool_valid pulses by default.
- frame_done asserts with the pool_valid of the last block (row floor(H/2)*2-1, col floor(W/2)*2-1).
  - When dimensions are odd, frame_done still coincides with that last output pulse, not with the frame's final input.
- Mid-frame reset: all counters return to zero, and the next valid pixel is treated as (0,0). No output is produced until a full even/odd row pair has been seen.
- Ties in max: either value, numerically identical.

Optional Feature:
- RELU_EN
  - Defined: ReLU applied as above; pool_out is always >= 0.
  - Undefined: ReLU bypassed (r = pixel_in); pure signed max pooling, and pool_out may be negative.
- Counting, latency and frame_done are identical in both builds.

Decomposition:
- Shared package cnn_pool_pkg holds:
  - CONV_OUT_W = 2*8+6.
  - Default IMG_WIDTH/IMG_HEIGHT constants.
  - A signed max function used by both compare points.
- One natural sub-module, pool_line_buffer:
  - Single-write, single-read array of floor(IMG_WIDTH/2) x DATA_WIDTH.
  - Combinational read, synchronous write, no reset on storage.
- Counters, pairing logic and output registers stay in the top module.

Test Plan:
- 4x4 frame (IMG_WIDTH=IMG_HEIGHT=4), continuous valid, inputs 1..16 raster -> 4 pulses with pool_out 6, 8, 14, 16; frame_done on the 4th pulse; each pulse exactly 1 cycle after pixels 6/8/14/16 are accepted.
- 4x4 frame, all inputs -5, RELU_EN defined -> four outputs of 0. Without RELU_EN -> four outputs of -5.
- 4x4 frame with pixel_valid deasserted every other cycle -> same values and order as the first scenario; no extra or missing pulses.
- 5x5 frame, inputs 1..25 -> exactly 4 outputs: 7, 9, 17, 19; column 4 and row 4 ignored; frame_done with the 4th pulse, none afterwards.
- rst asserted low after 6 pixels of a 4x4 frame, then a fresh frame 1..16 -> outputs 6, 8, 14, 16 only; pool_valid and frame_done are 0 during and immediately after reset.
- Two back-to-back 4x4 frames (second frame = first + 100) -> 8 pulses; second set is 106, 108, 114, 116; frame_done pulses twice.
